// File: rtl/uart_loopback_bist.sv
// rtl/uart_loopback_bist.sv - stop-and-wait UART loopback self-test engine
module uart_loopback_bist #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int NUM_FRAMES = 16,
  parameter int PATTERN    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 uart_rx_i,
  output logic                 uart_tx_o,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_cnt,
  output logic [15:0]          frame_cnt,
  output logic [DATA_BITS-1:0] last_sent,
  output logic [DATA_BITS-1:0] last_rcvd,
  output logic                 err_flag
);

  localparam int DIV        = CLK_FREQ / BAUD;
  localparam int HALF       = DIV / 2;
  localparam int PAR_BITS   = (PARITY != 0) ? 1 : 0;
  localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
  localparam int TO_LIMIT   = 2 * FRAME_BITS * DIV;
  localparam int DW         = $clog2(DIV + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_JUDGE, S_GAP} top_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;

  // Data for a given pattern index: a plain count, or alternating 0101/1010
  function automatic logic [DATA_BITS-1:0] pattern_of(input logic [DATA_BITS-1:0] idx);
    logic [DATA_BITS-1:0] p;
    p = idx;
    if (PATTERN != 0) begin
      for (int i = 0; i < DATA_BITS; i++) p[i] = (i % 2 == 1) ? idx[0] : ~idx[0];
    end
    return p;
  endfunction

  // Whole line frame, bit 0 first on the wire: start, data LSB first, parity, stops
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] d);
    logic [FRAME_BITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    f[DATA_BITS:1] = d;
    if (PARITY != 0) f[DATA_BITS+1] = (^d) ^ (PARITY == 2);
    return f;
  endfunction

  top_state_t            state;
  logic [DW-1:0]         div_cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [31:0]           to_cnt;
  logic [DATA_BITS-1:0]  pat_cnt;
  logic                  rx_got;
  logic                  to_hit;

  rx_state_t             rx_state;
  logic                  rx_s1, rx_s2, rx_s3;
  logic [DW-1:0]         rx_cnt;
  logic [3:0]            rx_bit;
  logic [DATA_BITS-1:0]  rx_shift;
  logic                  rx_par_bit;
  logic                  rx_done;
  logic                  rx_par_err;
  logic                  rx_stop_err;

  logic                  gap_end;
  logic                  launch;
  logic [DATA_BITS-1:0]  launch_data;
  logic [FRAME_BITS-1:0] launch_frame;
  logic                  timeout_now;
  logic                  rx_abort;
  logic                  frame_bad;

  assign gap_end      = (div_cnt == DW'(DIV - 1));
  assign launch       = ((state == S_IDLE) && start) ||
                        ((state == S_GAP) && gap_end && (frame_cnt != 16'(NUM_FRAMES)));
  assign launch_data  = pattern_of((state == S_IDLE) ? '0 : pat_cnt + 1'b1);
  assign launch_frame = build_frame(launch_data);
  assign timeout_now  = (to_cnt == 32'(TO_LIMIT - 1));
  // A timeout only counts when no frame arrived; an RX frame then in flight is dropped
  assign rx_abort     = (state == S_WAIT) && !rx_got && !rx_done && timeout_now;
  assign frame_bad    = to_hit || (last_rcvd != last_sent) || rx_par_err || rx_stop_err;

  // Top sequencer: launches frames, serialises them, waits, judges and spaces them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_shift  <= '1;
      to_cnt    <= '0;
      pat_cnt   <= '0;
      rx_got    <= 1'b0;
      to_hit    <= 1'b0;
      uart_tx_o <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      frame_cnt <= '0;
      last_sent <= '0;
      err_flag  <= 1'b0;
    end else begin
      err_flag <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            err_cnt   <= '0;
            frame_cnt <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            pat_cnt   <= '0;
          end
        end
        S_SEND: begin
          to_cnt <= to_cnt + 32'd1;
          if (rx_done) rx_got <= 1'b1;
          if (div_cnt == DW'(DIV - 1)) begin
            div_cnt <= '0;
            if (bit_cnt == 4'(FRAME_BITS - 1)) begin
              state <= S_WAIT;
            end else begin
              uart_tx_o <= tx_shift[0];
              tx_shift  <= {1'b1, tx_shift[FRAME_BITS-1:1]};
              bit_cnt   <= bit_cnt + 4'd1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          to_cnt <= to_cnt + 32'd1;
          if (rx_got || rx_done) begin
            to_hit <= 1'b0;
            state  <= S_JUDGE;
          end else if (timeout_now) begin
            to_hit <= 1'b1;
            state  <= S_JUDGE;
          end
        end
        S_JUDGE: begin
          err_flag <= frame_bad;
          if (frame_bad && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
          frame_cnt <= frame_cnt + 16'd1;
          div_cnt   <= '0;
          state     <= S_GAP;
        end
        S_GAP: begin
          if (gap_end) begin
            div_cnt <= '0;
            if (frame_cnt == 16'(NUM_FRAMES)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_cnt == 16'd0);
              state <= S_IDLE;
            end else begin
              pat_cnt <= pat_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (launch) begin
        uart_tx_o <= launch_frame[0];
        tx_shift  <= {1'b1, launch_frame[FRAME_BITS-1:1]};
        last_sent <= launch_data;
        bit_cnt   <= '0;
        div_cnt   <= '0;
        to_cnt    <= '0;
        rx_got    <= 1'b0;
        to_hit    <= 1'b0;
        state     <= S_SEND;
      end
    end
  end

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx_i;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // Receiver: mid-bit sampling, glitch rejection on the start bit, frame checks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state    <= R_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      rx_par_bit  <= 1'b0;
      rx_done     <= 1'b0;
      rx_par_err  <= 1'b0;
      rx_stop_err <= 1'b0;
      last_rcvd   <= '0;
    end else begin
      rx_done <= 1'b0;
      if (rx_abort) begin
        rx_state <= R_IDLE;
      end else begin
        case (rx_state)
          R_IDLE: begin
            if (rx_s3 && !rx_s2) begin
              rx_state <= R_START;
              rx_cnt   <= '0;
            end
          end
          R_START: begin
            if (rx_cnt == DW'(HALF - 1)) begin
              rx_cnt <= '0;
              rx_bit <= '0;
              rx_state <= rx_s2 ? R_IDLE : R_DATA;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          R_DATA: begin
            if (rx_cnt == DW'(DIV - 1)) begin
              rx_cnt   <= '0;
              rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
              if (rx_bit == 4'(DATA_BITS - 1)) rx_state <= (PARITY != 0) ? R_PAR : R_STOP;
              else rx_bit <= rx_bit + 4'd1;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          R_PAR: begin
            if (rx_cnt == DW'(DIV - 1)) begin
              rx_cnt     <= '0;
              rx_par_bit <= rx_s2;
              rx_state   <= R_STOP;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          R_STOP: begin
            if (rx_cnt == DW'(DIV - 1)) begin
              rx_cnt      <= '0;
              rx_done     <= 1'b1;
              last_rcvd   <= rx_shift;
              rx_stop_err <= !rx_s2;
              rx_par_err  <= (PARITY != 0) && (((^rx_shift) ^ rx_par_bit) != (PARITY == 2));
              rx_state    <= R_IDLE;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          default: rx_state <= R_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_loopback_bist.sv
// tb/tb_uart_loopback_bist.sv - randomized loopback bench with line fault injection
module tb_uart_loopback_bist;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [1:0] start, rx_line, tx, busy, done, pass, err_flag;
  logic [1:0] corrupt, glitch, tie_high;
  logic [1:0][15:0] err_cnt, frame_cnt;
  logic [1:0][7:0] last_sent, last_rcvd;
  logic [7:0] ls0, lr0;
  logic [6:0] ls1, lr1;
  logic [15:0] ec0, ec1, fc0, fc1;

  assign last_sent[0] = ls0;
  assign last_sent[1] = {1'b0, ls1};
  assign last_rcvd[0] = lr0;
  assign last_rcvd[1] = {1'b0, lr1};
  assign err_cnt[0]   = ec0;
  assign err_cnt[1]   = ec1;
  assign frame_cnt[0] = fc0;
  assign frame_cnt[1] = fc1;
  assign rx_line      = tie_high | ((tx ^ corrupt) & ~glitch);

  uart_loopback_bist #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                       .STOP_BITS(1), .NUM_FRAMES(4), .PATTERN(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .uart_rx_i(rx_line[0]), .uart_tx_o(tx[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(ec0), .frame_cnt(fc0),
    .last_sent(ls0), .last_rcvd(lr0), .err_flag(err_flag[0]));

  uart_loopback_bist #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2),
                       .STOP_BITS(2), .NUM_FRAMES(3), .PATTERN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .uart_rx_i(rx_line[1]), .uart_tx_o(tx[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(ec1), .frame_cnt(fc1),
    .last_sent(ls1), .last_rcvd(lr1), .err_flag(err_flag[1]));

  function automatic int db(input int i);  return (i == 0) ? 8 : 7; endfunction
  function automatic int pm(input int i);  return (i == 0) ? 0 : 2; endfunction
  function automatic int sb(input int i);  return (i == 0) ? 1 : 2; endfunction
  function automatic int nf(input int i);  return (i == 0) ? 4 : 3; endfunction
  function automatic int pt(input int i);  return (i == 0) ? 0 : 1; endfunction
  function automatic int pb(input int i);  return (pm(i) != 0) ? 1 : 0; endfunction
  function automatic int fbits(input int i); return 1 + db(i) + pb(i) + sb(i); endfunction

  function automatic int exp_data(input int i, input int k);
    int mask = (1 << db(i)) - 1;
    if (pt(i) == 0) return k & mask;
    return (k % 2 == 0) ? ('h555 & mask) : ('hAAA & mask);
  endfunction

  function automatic int exp_par(input int i, input int d);
    int ones = $countones(d) % 2;
    return (pm(i) == 1) ? ones : 1 - ones;
  endfunction

  function automatic logic [15:0] exp_frame(input int i, input int k);
    int d = exp_data(i, k);
    int f = d << 1;
    if (pm(i) != 0) f = f | (exp_par(i, d) << (db(i) + 1));
    for (int s = 0; s < sb(i); s++) f = f | (1 << (db(i) + 1 + pb(i) + s));
    return 16'(f);
  endfunction

  // fault kinds: 0 clean, 1 flip a data bit, 2 first stop bit low, 3 line tied high, 4 flip parity
  int kind[2], ffrm[2], fbit[2];

  function automatic int fault_pos(input int i);
    case (kind[i])
      1: return 1 + fbit[i];
      2: return 1 + db(i) + pb(i);
      4: return 1 + db(i);
      default: return -1;
    endcase
  endfunction

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  int in_frame[2], cyc[2], fidx[2], frames_seen[2], flag_pulses[2], run_len[2];
  bit busy_q[2], counting[2];
  logic [15:0] first_bits[2], last_bits[2];

  task automatic mon_step(input int i);
    int b, r;
    if (!rst_n) begin
      in_frame[i] = 0; corrupt[i] = 1'b0; busy_q[i] = 1'b0; counting[i] = 1'b0;
      return;
    end
    if (busy[i] && !busy_q[i]) begin
      fidx[i] = 0; frames_seen[i] = 0; flag_pulses[i] = 0; run_len[i] = 0; counting[i] = 1'b1;
    end
    busy_q[i] = busy[i];
    if (counting[i]) begin
      if (done[i]) counting[i] = 1'b0;
      else run_len[i]++;
    end
    if (err_flag[i]) begin
      flag_pulses[i]++;
      if (kind[i] == 1)
        check($sformatf("u%0d_rcvd_at_flag", i), last_rcvd[i], exp_data(i, ffrm[i]) ^ (1 << fbit[i]));
    end
    if (in_frame[i] == 0) begin
      if (tx[i] == 1'b0) begin
        in_frame[i] = 1; cyc[i] = 0; first_bits[i] = '0; last_bits[i] = '0;
      end
    end else begin
      cyc[i]++;
    end
    if (in_frame[i] != 0) begin
      b = cyc[i] / DIV;
      r = cyc[i] % DIV;
      if (r == 0) first_bits[i][b] = tx[i];
      if (r == DIV - 1) last_bits[i][b] = tx[i];
      corrupt[i] = (fidx[i] == ffrm[i]) && (b == fault_pos(i));
      if (cyc[i] == fbits(i) * DIV - 1) begin
        check($sformatf("u%0d_tx_head_f%0d", i, fidx[i]), first_bits[i], exp_frame(i, fidx[i]));
        check($sformatf("u%0d_tx_tail_f%0d", i, fidx[i]), last_bits[i], exp_frame(i, fidx[i]));
        in_frame[i] = 0; corrupt[i] = 1'b0; fidx[i]++; frames_seen[i]++;
      end
    end
  endtask

  initial begin
    corrupt = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) mon_step(i);
    end
  end

  task automatic reset_checks(input string when);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_u%0d_tx", when, i), tx[i], 1);
      check($sformatf("%s_u%0d_busy", when, i), busy[i], 0);
      check($sformatf("%s_u%0d_done", when, i), done[i], 0);
      check($sformatf("%s_u%0d_pass", when, i), pass[i], 0);
      check($sformatf("%s_u%0d_errcnt", when, i), err_cnt[i], 0);
      check($sformatf("%s_u%0d_framecnt", when, i), frame_cnt[i], 0);
      check($sformatf("%s_u%0d_lsent", when, i), last_sent[i], 0);
      check($sformatf("%s_u%0d_lrcvd", when, i), last_rcvd[i], 0);
      check($sformatf("%s_u%0d_errflag", when, i), err_flag[i], 0);
    end
  endtask

  task automatic wait_done(input logic [1:0] mask);
    int n = 0;
    while (((done & mask) != mask) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("run_completes", ((done & mask) == mask), 1);
  endtask

  task automatic end_checks(input int i);
    int exp_err;
    int exp_lr;
    exp_err = (kind[i] == 3) ? nf(i) : (kind[i] == 0) ? 0 : 1;
    check($sformatf("u%0d_errcnt_k%0d", i, kind[i]), err_cnt[i], exp_err);
    check($sformatf("u%0d_framecnt", i), frame_cnt[i], nf(i));
    check($sformatf("u%0d_done", i), done[i], 1);
    check($sformatf("u%0d_busy", i), busy[i], 0);
    check($sformatf("u%0d_pass", i), pass[i], (exp_err == 0) ? 1 : 0);
    check($sformatf("u%0d_lsent", i), last_sent[i], exp_data(i, nf(i) - 1));
    check($sformatf("u%0d_flag_pulses", i), flag_pulses[i], exp_err);
    check($sformatf("u%0d_frames_on_line", i), frames_seen[i], nf(i));
    if (kind[i] == 3) begin
      check($sformatf("u%0d_timeout_run_len", i), run_len[i],
            nf(i) * (2 * fbits(i) * DIV + 1 + DIV));
    end else begin
      exp_lr = exp_data(i, nf(i) - 1);
      if (kind[i] == 1 && ffrm[i] == nf(i) - 1) exp_lr = exp_lr ^ (1 << fbit[i]);
      check($sformatf("u%0d_lrcvd", i), last_rcvd[i], exp_lr);
    end
  endtask

  task automatic setup_faults(input int k0, input int k1);
    kind[0] = k0;
    kind[1] = k1;
    for (int i = 0; i < 2; i++) begin
      ffrm[i] = int'($urandom_range(nf(i) - 1, 0));
      fbit[i] = int'($urandom_range(db(i) - 1, 0));
      tie_high[i] = (kind[i] == 3);
    end
  endtask

  task automatic do_run(input int k0, input int k1);
    setup_faults(k0, k1);
    @(negedge clk);
    start = 2'b11;
    @(negedge clk);
    start = 2'b00;
    wait_done(2'b11);
    for (int i = 0; i < 2; i++) end_checks(i);
    tie_high = '0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = '0; glitch = '0; tie_high = '0;
    kind = '{0, 0}; ffrm = '{-1, -1}; fbit = '{0, 0};
    repeat (3) @(posedge clk);
    #2;
    reset_checks("reset");
    @(negedge clk);
    rst_n = 1'b1;

    do_run(0, 0);
    // short low glitch on an idle line must not produce a frame
    @(negedge clk);
    glitch = 2'b11;
    repeat (3) @(negedge clk);
    glitch = 2'b00;
    repeat (40) @(negedge clk);
    for (int i = 0; i < 2; i++)
      check($sformatf("u%0d_glitch_no_frame", i), last_rcvd[i], exp_data(i, nf(i) - 1));

    do_run(1, 4);
    do_run(2, 2);
    do_run(3, 3);
    do_run(0, 1);
    for (int r = 0; r < 5; r++) do_run(int'($urandom_range(3, 0)), int'($urandom_range(4, 0)));

    // start held high across the end of a run restarts immediately
    setup_faults(0, 0);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    wait_done(2'b01);
    @(negedge clk);
    check("hold_restart_busy", busy[0], 1);
    check("hold_restart_done", done[0], 0);
    start[0] = 1'b0;
    @(negedge clk);
    wait_done(2'b01);
    end_checks(0);

    // reset in the middle of a data bit of frame 1
    setup_faults(0, 0);
    @(negedge clk);
    start = 2'b11;
    @(negedge clk);
    start = 2'b00;
    n = 0;
    while (!(fidx[0] == 1 && in_frame[0] != 0 && cyc[0] == 3 * DIV + 4) && n < 5000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("reach_frame1_data", n < 5000, 1);
    #1;
    rst_n = 1'b0;
    #1;
    reset_checks("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_run(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_loopback_bist.md
Name: uart_loopback_bist

Overview:
- Synthesizable, parametrised UART built-in self-test engine that generates a frame pattern, serialises it on uart_tx_o, deserialises uart_rx_i and checks each received frame against the frame it sent.
- It replaces the bench-only loopback check, where TX is tied to RX, with on-chip hardware for SoC bring-up.
- It runs stop-and-wait: one frame in flight at a time, judged before the next frame is sent.
- It reports per-frame errors, a saturating error count and a final pass/fail.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz.
- BAUD, 115_200, line rate; DIV = CLK_FREQ/BAUD (integer division), with DIV >= 4 required.
- DATA_BITS, 8, data bits per frame, legal range 5..9, sent LSB first.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, number of stop bits, 1 or 2.
- NUM_FRAMES, 16, number of frames per run, 1..65535.
- PATTERN, 0, data pattern: 0 incrementing from 0; 1 alternating, with even frames {..0101} and odd frames {..1010}.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level-sampled each cycle; starts a run when idle, ignored while busy.
- uart_rx_i  in  1  serial input, asynchronous to clk, idle high.
- uart_tx_o  out  1  serial output, idle high.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run end until the next accepted start.
- pass  out  1  done && err_cnt == 0.
- err_cnt  out  16  errored-frame count, saturates at 0xFFFF.
- frame_cnt  out  16  frames judged in the current run.
- last_sent  out  DATA_BITS  data of the most recent transmitted frame.
- last_rcvd  out  DATA_BITS  data of the most recent received frame.
- err_flag  out  1  one-cycle pulse when a frame is judged bad.

Behaviour:
- Reset values: uart_tx_o=1; busy=0; done=0; pass=0; err_cnt=0; frame_cnt=0; last_sent=0; last_rcvd=0; err_flag=0. Both FSMs are in IDLE.
- Reset mid-frame: uart_tx_o returns to 1 immediately (asynchronous), and the run is abandoned.
- Top FSM states: IDLE, SEND, WAIT, JUDGE, GAP.
  - IDLE with start=1: clear err_cnt, frame_cnt and done; load the pattern counter with 0; set busy; go to SEND. The start bit appears on uart_tx_o on the next cycle.
  - SEND: the TX shifter emits start(0), data LSB first, optional parity, then STOP_BITS stop bits (1). Each bit lasts exactly DIV cycles. last_sent is updated at the start bit. On the end of the last stop bit, go to WAIT.
  - WAIT: wait for rx_done or timeout. The timeout counter starts at the TX start bit; the limit is 2 × frame_bits × DIV cycles, where frame_bits = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS.
  - JUDGE (one cycle): a frame is bad if any of these holds: data mismatch, parity error, first stop bit sampled 0, or timeout. A bad frame pulses err_flag and increments err_cnt (saturating). A frame with multiple faults counts once. frame_cnt increments in all cases.
  - GAP: idle line for DIV cycles. Then, if frame_cnt == NUM_FRAMES, clear busy, set done and go to IDLE. Otherwise advance the pattern counter (mod 2^DATA_BITS) and go to SEND.
- RX path:
  - uart_rx_i passes through a 2-flop synchroniser.
  - A falling edge is accepted only in the RX IDLE state.
  - The line is re-sampled at DIV/2. If it is high, treat it as a glitch and return to IDLE; no frame is produced.
  - Each subsequent bit is sampled every DIV cycles, at mid-bit.
  - rx_done pulses once after the first stop bit is sampled, and last_rcvd is loaded at the same time.
  - RX continues to run while the top FSM is in IDLE or GAP, but frames received in those states are not judged.
- Parity: even means the XOR of data bits and parity bit is 0; odd means that XOR is 1. With PARITY=0 there is no parity bit and no parity check.
- Timeout:
  - Takes effect only in WAIT.
  - If rx_done and the timeout occur in the same cycle, rx_done wins and the frame is judged on its content.
  - An RX frame still in progress when the timeout fires is discarded: the RX FSM is forced to IDLE.
- start held high across run end: a new run begins in the cycle after done rises, and done is then cleared.

Test Plan:
- CLK_FREQ=1_000_000, BAUD=100_000 (DIV=10), 8N1, NUM_FRAMES=4, TX looped to RX, start pulsed -> frames 0x00..0x03 sent, each frame 100 cycles on the line; done=1, pass=1, err_cnt=0, frame_cnt=4.
- Same setup, PARITY=1, PATTERN=1 -> bytes 0x55, 0xAA, 0x55, 0xAA. Parity bit is 0 for every frame (0x55 and 0xAA each have four 1s). pass=1.
- Loopback with the bench inverting bit 0 of frame 2 (0x02 becomes 0x03) -> err_flag pulses once during frame 2, err_cnt=1, pass=0, last_rcvd=0x03 at that judge.
- uart_rx_i tied high, NUM_FRAMES=2 -> each frame times out after 200 cycles, err_cnt=2, done=1, pass=0.
- Stop bit forced to 0 on frame 1 -> framing error, err_cnt=1. Also a 3-cycle low glitch while RX is idle -> no frame produced and no extra count.
- Assert rst_n low mid data bit of frame 1 -> uart_tx_o=1 and all outputs at reset values within the same cycle. A fresh start then completes with pass=1.
